// File: rtl/i2s_stereo_tx.sv
// Stereo I2S / left-justified transmitter with a frame FIFO in front of the serializer.
// BCLK and LRCLK are derived from clk; every serial output is registered.
module i2s_stereo_tx #(
    parameter int DATA_W     = 24,
    parameter int SLOT_W     = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int BCLK_DIV   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          mode,
    input  logic [DATA_W-1:0]             in_left,
    input  logic [DATA_W-1:0]             in_right,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          bclk,
    output logic                          lrclk,
    output logic                          sdata,
    output logic                          underflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int FRM_W = 2 * SLOT_W;
    localparam int CNT_W = $clog2(FRM_W);
    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRM_W - 1);
    localparam logic [CNT_W-1:0] SLOT_L   = CNT_W'(SLOT_W);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [LVL_W-1:0] DEPTH_L  = LVL_W'(FIFO_DEPTH);

    logic [DATA_W-1:0] mem_l [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;

    logic [DIV_W-1:0]  div_cnt;
    logic [CNT_W-1:0]  bit_cnt, next_bit;
    logic [FRM_W-1:0]  shreg, frame_word;
    logic              cur_mode, lj_bit;
    logic              push, pop, fall_evt, frame_start;

    // Ready comes from the registered level only: a pop in the same cycle never frees a slot early.
    assign in_ready    = (fifo_level < DEPTH_L);
    assign push        = in_valid && in_ready;
    assign fall_evt    = enable && (div_cnt == DIV_LAST) && bclk;
    assign frame_start = fall_evt && (bit_cnt == LAST_BIT);
    assign pop         = frame_start && (fifo_level != '0);
    assign next_bit    = (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_l[wr_ptr] <= in_left;
            mem_r[wr_ptr] <= in_right;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // An empty FIFO at frame start sends a silent frame.
    always_comb begin
        frame_word = '0;
        if (pop) begin
            frame_word[FRM_W-1 -: DATA_W]  = mem_l[rd_ptr];
            frame_word[SLOT_W-1 -: DATA_W] = mem_r[rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt   <= '0;
            bclk      <= 1'b0;
            bit_cnt   <= LAST_BIT;
            lrclk     <= 1'b0;
            sdata     <= 1'b0;
            lj_bit    <= 1'b0;
            cur_mode  <= 1'b0;
            shreg     <= '0;
            underflow <= 1'b0;
        end else begin
            underflow <= frame_start && (fifo_level == '0);
            if (!enable) begin
                // Parking the bit counter on the last bit makes the first fall event a frame start.
                div_cnt <= '0;
                bclk    <= 1'b0;
                bit_cnt <= LAST_BIT;
                lrclk   <= 1'b0;
                sdata   <= 1'b0;
                lj_bit  <= 1'b0;
                shreg   <= '0;
            end else begin
                div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
                if (div_cnt == DIV_LAST) bclk <= ~bclk;
                if (fall_evt) begin
                    bit_cnt <= next_bit;
                    lrclk   <= (next_bit >= SLOT_L);
                    // lj_bit holds the previous left-justified bit, which is exactly the I2S bit.
                    if (frame_start) begin
                        cur_mode <= mode;
                        shreg    <= {frame_word[FRM_W-2:0], 1'b0};
                        lj_bit   <= frame_word[FRM_W-1];
                        sdata    <= mode ? frame_word[FRM_W-1] : lj_bit;
                    end else begin
                        shreg    <= {shreg[FRM_W-2:0], 1'b0};
                        lj_bit   <= shreg[FRM_W-1];
                        sdata    <= cur_mode ? shreg[FRM_W-1] : lj_bit;
                    end
                end
            end
        end
    end

endmodule
